// File: rtl/iot_active_monitor_multi.sv
// iot_active_monitor_multi: per-channel active-device counters with sticky errors, threshold alarms, read-back and total
module iot_active_monitor_multi #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int TOT_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               change,
  input  logic               on_off,
  input  logic [CH_W-1:0]    ch_sel,
  input  logic               mode,
  input  logic [WIDTH-1:0]   thresh,
  input  logic [CH_W-1:0]    rd_sel,
  output logic [WIDTH-1:0]   rd_count,
  output logic [TOT_W-1:0]   total,
  output logic [N_CH-1:0]    alarm,
  output logic [N_CH-1:0]    err_flags
);
  logic [WIDTH-1:0] cnt     [N_CH];
  logic [WIDTH-1:0] cnt_nxt [N_CH];
  logic [N_CH-1:0]  hit, bnd, err_hit, alarm_nxt;
  logic [WIDTH-1:0] rd_nxt;
  logic [TOT_W-1:0] sum;
  // Channel select is matched per channel, so out-of-range ch_sel/rd_sel simply hit nothing.
  always_comb begin
    cnt_nxt   = cnt;
    hit       = '0;
    bnd       = '0;
    err_hit   = '0;
    alarm_nxt = '0;
    rd_nxt    = '0;
    sum       = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i]       = change && ch_sel == CH_W'(i);
      bnd[i]       = on_off ? &cnt[i] : ~|cnt[i];
      err_hit[i]   = hit[i] && bnd[i];
      cnt_nxt[i]   = (!hit[i] || (bnd[i] && mode)) ? cnt[i] :
                     on_off ? cnt[i] + WIDTH'(1) : cnt[i] - WIDTH'(1);
      alarm_nxt[i] = cnt[i] >= thresh;
      rd_nxt       = rd_sel == CH_W'(i) ? cnt[i] : rd_nxt;
      sum          = sum + TOT_W'(cnt[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      err_flags <= '0;
      rd_count  <= '0;
      total     <= '0;
      alarm     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= clr ? '0 : cnt_nxt[i];
      err_flags <= clr ? '0 : err_flags | err_hit;
      rd_count  <= rd_nxt;
      total     <= sum;
      alarm     <= alarm_nxt;
    end
  end
endmodule

// File: tb/tb_iot_active_monitor_multi.sv
// tb_iot_active_monitor_multi: vector table plus random stimulus checked against a reference model via a scoreboard
module tb_iot_active_monitor_multi;
  localparam int W = 8, N = 4, CW = 2, TW = 12;
  logic clk = 0, rst_n = 0, clr = 0, change = 0, on_off = 0, mode = 0;
  logic [CW-1:0] ch_sel = '0, rd_sel = '0;
  logic [W-1:0]  thresh = '0;
  logic [W-1:0]  rd_a, rd_b;
  logic [TW-1:0] tot_a, tot_b;
  logic [N-1:0]  al_a, er_a;
  logic [2:0]    al_b, er_b;

  typedef struct {
    bit clr, change, on_off, mode;
    int ch, rd, thresh, exp_rd;
  } vec_t;
  typedef struct {
    logic [W-1:0]  rd_a, rd_b;
    logic [TW-1:0] tot_a, tot_b;
    logic [N-1:0]  al_a, er_a, al_b, er_b;
    int            exp_rd;
  } exp_t;

  int   n_vec = 0, n_bad = 0;
  vec_t vt[$];
  exp_t sb[$];
  int   mc [2][N];
  bit   me [2][N];

  iot_active_monitor_multi #(.WIDTH(W), .N_CH(N), .CH_W(CW), .TOT_W(TW)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .change(change), .on_off(on_off), .ch_sel(ch_sel),
    .mode(mode), .thresh(thresh), .rd_sel(rd_sel), .rd_count(rd_a), .total(tot_a),
    .alarm(al_a), .err_flags(er_a));
  iot_active_monitor_multi #(.WIDTH(W), .N_CH(3), .CH_W(CW), .TOT_W(TW)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .change(change), .on_off(on_off), .ch_sel(ch_sel),
    .mode(mode), .thresh(thresh), .rd_sel(rd_sel), .rd_count(rd_b), .total(tot_b),
    .alarm(al_b), .err_flags(er_b));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_zero(string nm);
    n_vec++;
    chk({nm, " rd_a"}, rd_a, 0);  chk({nm, " tot_a"}, tot_a, 0);
    chk({nm, " al_a"}, al_a, 0);  chk({nm, " er_a"}, er_a, 0);
    chk({nm, " rd_b"}, rd_b, 0);  chk({nm, " tot_b"}, tot_b, 0);
    chk({nm, " al_b"}, al_b, 0);  chk({nm, " er_b"}, er_b, 0);
  endfunction

  function automatic void mreset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        mc[d][i] = 0;
        me[d][i] = 0;
      end
  endfunction

  // Outputs observed after an edge reflect counts before it; err flags reflect counts after it.
  function automatic void model(input int d, input int n, output logic [W-1:0] rd,
                                output logic [TW-1:0] tot, output logic [N-1:0] al, output logic [N-1:0] er);
    int c;
    rd  = (int'(rd_sel) < n) ? W'(mc[d][rd_sel]) : '0;
    tot = '0;
    al  = '0;
    er  = '0;
    for (int i = 0; i < n; i++) begin
      tot   = tot + TW'(mc[d][i]);
      al[i] = mc[d][i] >= int'(thresh);
    end
    c = int'(ch_sel);
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        mc[d][i] = 0;
        me[d][i] = 0;
      end
    end else if (change && c < n) begin
      if (on_off) begin
        if (mc[d][c] == 255) begin
          me[d][c] = 1;
          if (!mode) mc[d][c] = 0;
        end else mc[d][c]++;
      end else begin
        if (mc[d][c] == 0) begin
          me[d][c] = 1;
          if (!mode) mc[d][c] = 255;
        end else mc[d][c]--;
      end
    end
    for (int i = 0; i < n; i++) er[i] = me[d][i];
  endfunction

  function automatic void add(bit c, bit chg, bit oo, bit md, int chn, int rs, int th, int erd = -1);
    vec_t v;
    v.clr = c; v.change = chg; v.on_off = oo; v.mode = md;
    v.ch = chn; v.rd = rs; v.thresh = th; v.exp_rd = erd;
    vt.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    clr = v.clr; change = v.change; on_off = v.on_off; mode = v.mode;
    ch_sel = CW'(v.ch); rd_sel = CW'(v.rd); thresh = W'(v.thresh);
    model(0, N, e.rd_a, e.tot_a, e.al_a, e.er_a);
    model(1, 3, e.rd_b, e.tot_b, e.al_b, e.er_b);
    e.exp_rd = v.exp_rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    chk("rd_a", rd_a, e.rd_a);            chk("tot_a", tot_a, e.tot_a);
    chk("al_a", al_a, e.al_a);            chk("er_a", er_a, e.er_a);
    chk("rd_b", rd_b, e.rd_b);            chk("tot_b", tot_b, e.tot_b);
    chk("al_b", {1'b0, al_b}, e.al_b);    chk("er_b", {1'b0, er_b}, e.er_b);
    if (e.exp_rd >= 0) chk("rd_directed", rd_a, e.exp_rd);
  endtask

  initial begin
    change = 1; on_off = 1; rst_n = 0;
    repeat (3) begin
      @(posedge clk);
      #1 chk_zero("reset_hold");
    end
    @(negedge clk);
    rst_n = 1; change = 0;
    mreset();
    repeat (3) add(0, 0, 0, 1, 0, 0, 4);
    repeat (5) add(0, 1, 1, 1, 1, 1, 4);
    repeat (2) add(0, 1, 0, 1, 1, 1, 4);
    add(0, 0, 0, 1, 0, 1, 4, 3);
    repeat (256) add(0, 1, 1, 1, 2, 2, 4);
    add(0, 0, 0, 1, 0, 2, 4, 255);
    add(1, 1, 1, 1, 0, 2, 4);
    add(0, 1, 0, 1, 2, 2, 4);
    add(0, 0, 0, 1, 0, 2, 4, 0);
    repeat (255) add(0, 1, 1, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 4, 255);
    add(0, 1, 1, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 4, 255);
    add(0, 0, 0, 0, 0, 1, 4);
    add(1, 0, 0, 1, 0, 3, 4);
    repeat (3) add(0, 1, 1, 1, 3, 3, 4);
    add(0, 0, 0, 1, 0, 3, 4, 3);
    add(0, 1, 1, 1, 3, 3, 4);
    add(0, 0, 0, 1, 0, 3, 4, 4);
    add(0, 1, 0, 1, 3, 3, 4);
    add(0, 0, 0, 1, 0, 3, 4, 3);
    add(0, 0, 0, 1, 0, 3, 0);
    add(0, 1, 0, 1, 3, 2, 0);
    add(1, 1, 1, 1, 0, 0, 4);
    add(0, 0, 0, 1, 0, 0, 4, 0);
    foreach (vt[i]) apply(vt[i]);
    repeat (400) begin
      vec_t v;
      v.clr    = $urandom_range(0, 39) == 0;
      v.change = $urandom_range(0, 3) != 0;
      v.on_off = $urandom_range(0, 1);
      v.mode   = $urandom_range(0, 1);
      v.ch     = $urandom_range(0, 3);
      v.rd     = $urandom_range(0, 3);
      v.thresh = $urandom_range(0, 6);
      v.exp_rd = -1;
      apply(v);
    end
    @(negedge clk);
    change = 1; on_off = 1; clr = 0; ch_sel = 1;
    #2 rst_n = 0;
    #1 chk_zero("async_reset");
    repeat (2) begin
      @(posedge clk);
      #1 chk_zero("reset_mid");
    end
    @(negedge clk);
    rst_n = 1; change = 0;
    mreset();
    begin
      vec_t v;
      v.clr = 0; v.change = 0; v.on_off = 0; v.mode = 0;
      v.ch = 0; v.rd = 1; v.thresh = 1; v.exp_rd = 0;
      apply(v);
      v.change = 1; v.on_off = 1; v.ch = 1;
      apply(v);
      v.change = 0;
      v.exp_rd = 1;
      apply(v);
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
